// File: rtl/axi_lite_ptgen_master.sv
// AXI4-Lite pattern generator / checker master.
// Writes an incrementing data pattern to a strided address range, reads it
// back and compares, counting response and data errors. One transaction is
// outstanding at a time.
module axi_lite_ptgen_master #(
   parameter int                            C_M_AXI_ADDR_WIDTH         = 32,
   parameter int                            C_M_AXI_DATA_WIDTH         = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
   parameter int                            C_M_TRANSACTIONS_NUM       = 4,
   parameter int                            C_ADDR_STRIDE              = 4,
   parameter logic [31:0]                   C_PATTERN_SEED             = 32'hA5A5_0000,
   parameter int                            C_ERR_CNT_WIDTH            = 8
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESET,
   input  logic                              INIT_AXI_TXN,
   input  logic [1:0]                        MODE,
   output logic                              TXN_DONE,
   output logic                              ERROR,
   output logic [C_ERR_CNT_WIDTH-1:0]        ERR_COUNT,
   output logic                              BUSY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int AW    = C_M_AXI_ADDR_WIDTH;
   localparam int DW    = C_M_AXI_DATA_WIDTH;
   localparam int EW    = C_ERR_CNT_WIDTH;
   localparam int IDX_W = (C_M_TRANSACTIONS_NUM > 1) ? $clog2(C_M_TRANSACTIONS_NUM) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_M_TRANSACTIONS_NUM - 1);
   localparam logic [AW-1:0]    STRIDE_A = AW'(C_ADDR_STRIDE);
   localparam logic [DW-1:0]    SEED_D   = DW'(C_PATTERN_SEED);

   localparam logic [1:0] MODE_WR_RD = 2'b00;
   localparam logic [1:0] MODE_WR    = 2'b01;
   localparam logic [1:0] MODE_RD    = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [1:0]         mode_reg, mode_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [AW-1:0]      addr_reg, addr_next;
   logic [DW-1:0]      data_reg, data_next;
   logic               aw_done_reg, aw_done_next;
   logic               w_done_reg, w_done_next;
   logic               err_reg, err_next;
   logic [EW-1:0]      err_cnt_reg, err_cnt_next;

   logic               init_q_reg, init_d_reg, start_reg;
   logic               err_event;
   logic [1:0]         mode_norm;

   // Low bits of the responses only distinguish OKAY/EXOKAY and are not needed.
   logic               unused_resp;
   assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

   // Mode 11 behaves as write-then-read.
   assign mode_norm = (MODE == 2'b11) ? MODE_WR_RD : MODE;

   // Start detector: register INIT, then register the rising edge so the
   // FSM sees a clean one-cycle start pulse. Reset primes the history high
   // so an INIT held through reset does not count as a new edge.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         init_q_reg <= 1'b1;
         init_d_reg <= 1'b1;
         start_reg  <= 1'b0;
      end else begin
         init_q_reg <= INIT_AXI_TXN;
         init_d_reg <= init_q_reg;
         start_reg  <= init_q_reg & ~init_d_reg;
      end
   end

   // State and datapath registers.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state_reg   <= IDLE;
         mode_reg    <= MODE_WR_RD;
         idx_reg     <= '0;
         addr_reg    <= '0;
         data_reg    <= '0;
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         err_reg     <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         mode_reg    <= mode_next;
         idx_reg     <= idx_next;
         addr_reg    <= addr_next;
         data_reg    <= data_next;
         aw_done_reg <= aw_done_next;
         w_done_reg  <= w_done_next;
         err_reg     <= err_next;
         err_cnt_reg <= err_cnt_next;
      end
   end

   // Next-state logic, channel handshakes and error accounting.
   always_comb begin
      state_next    = state_reg;
      mode_next     = mode_reg;
      idx_next      = idx_reg;
      addr_next     = addr_reg;
      data_next     = data_reg;
      aw_done_next  = aw_done_reg;
      w_done_next   = w_done_reg;
      err_next      = err_reg;
      err_cnt_next  = err_cnt_reg;
      err_event     = 1'b0;
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;

      case (state_reg)
         IDLE, DONE: begin
            if (start_reg) begin
               mode_next    = mode_norm;
               idx_next     = '0;
               addr_next    = C_M_TARGET_SLAVE_BASE_ADDR;
               data_next    = SEED_D;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               err_next     = 1'b0;
               err_cnt_next = '0;
               state_next   = (mode_norm == MODE_RD) ? RD_ADDR : WR_ADDR_DATA;
            end
         end

         WR_ADDR_DATA: begin
            // AW and W are presented together and retire independently.
            M_AXI_AWVALID = ~aw_done_reg;
            M_AXI_WVALID  = ~w_done_reg;
            aw_done_next  = aw_done_reg | M_AXI_AWREADY;
            w_done_next   = w_done_reg | M_AXI_WREADY;
            if (aw_done_next && w_done_next) begin
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               state_next   = WR_RESP;
            end
         end

         WR_RESP: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) begin
               err_event = M_AXI_BRESP[1];
               if (idx_reg == LAST_IDX) begin
                  if (mode_reg == MODE_WR) begin
                     state_next = DONE;
                  end else begin
                     idx_next   = '0;
                     addr_next  = C_M_TARGET_SLAVE_BASE_ADDR;
                     data_next  = SEED_D;
                     state_next = RD_ADDR;
                  end
               end else begin
                  idx_next   = idx_reg + IDX_W'(1);
                  addr_next  = addr_reg + STRIDE_A;
                  data_next  = data_reg + DW'(1);
                  state_next = WR_ADDR_DATA;
               end
            end
         end

         RD_ADDR: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) begin
               state_next = RD_DATA;
            end
         end

         RD_DATA: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) begin
               // A bad response and a data mismatch on one beat count once.
               err_event = M_AXI_RRESP[1] | (M_AXI_RDATA != data_reg);
               if (idx_reg == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx_reg + IDX_W'(1);
                  addr_next  = addr_reg + STRIDE_A;
                  data_next  = data_reg + DW'(1);
                  state_next = RD_ADDR;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (err_event) begin
         err_next = 1'b1;
         if (err_cnt_reg != {EW{1'b1}}) begin
            err_cnt_next = err_cnt_reg + EW'(1);
         end
      end
   end

   assign M_AXI_AWADDR = addr_reg;
   assign M_AXI_ARADDR = addr_reg;
   assign M_AXI_WDATA  = data_reg;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   assign TXN_DONE  = (state_reg == DONE);
   assign BUSY      = (state_reg != IDLE) && (state_reg != DONE);
   assign ERROR     = err_reg;
   assign ERR_COUNT = err_cnt_reg;

endmodule

// File: tb/tb_axi_lite_ptgen_master.sv
// Bench for axi_lite_ptgen_master: memory slave with configurable ready/
// response delays and fault injection, scoreboard queues of expected
// write/read transactions, and end-of-run status checks.
module tb_axi_lite_ptgen_master;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] SEED = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        M_AXI_ARESET = 1'b1;
   logic        INIT_AXI_TXN = 1'b0;
   logic [1:0]  MODE = 2'b00;
   logic        TXN_DONE, ERROR, BUSY;
   logic [1:0]  ERR_COUNT;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
   logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
   logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
   logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
   logic [31:0] M_AXI_RDATA = '0;

   int tests_run = 0;
   int tests_failed = 0;

   // slave configuration
   int          aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [3:0]  corrupt_mask = '0, bresp_mask = '0;

   // slave state
   logic [31:0] mem [0:15];
   logic        aw_got = 0, w_got = 0, ar_got = 0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] aw_a = '0, w_d = '0, ar_a = '0;
   logic        aw_pend = 0, w_pend = 0, ar_pend = 0;

   wr_t         wr_q[$];
   logic [31:0] rd_q[$];

   axi_lite_ptgen_master #(
      .C_ERR_CNT_WIDTH(2)
   ) dut (
      .M_AXI_ACLK   (clk),
      .M_AXI_ARESET (M_AXI_ARESET),
      .INIT_AXI_TXN (INIT_AXI_TXN),
      .MODE         (MODE),
      .TXN_DONE     (TXN_DONE),
      .ERROR        (ERROR),
      .ERR_COUNT    (ERR_COUNT),
      .BUSY         (BUSY),
      .M_AXI_AWADDR (M_AXI_AWADDR),
      .M_AXI_AWPROT (M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID),
      .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA  (M_AXI_WDATA),
      .M_AXI_WSTRB  (M_AXI_WSTRB),
      .M_AXI_WVALID (M_AXI_WVALID),
      .M_AXI_WREADY (M_AXI_WREADY),
      .M_AXI_BRESP  (M_AXI_BRESP),
      .M_AXI_BVALID (M_AXI_BVALID),
      .M_AXI_BREADY (M_AXI_BREADY),
      .M_AXI_ARADDR (M_AXI_ARADDR),
      .M_AXI_ARPROT (M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA  (M_AXI_RDATA),
      .M_AXI_RRESP  (M_AXI_RRESP),
      .M_AXI_RVALID (M_AXI_RVALID),
      .M_AXI_RREADY (M_AXI_RREADY)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] widx(input logic [31:0] a);
      logic [31:0] t;
      t = (a - BASE) >> 2;
      return t[3:0];
   endfunction

   // Memory slave. Everything happens on the falling edge: READY/VALID are
   // driven for the coming rising edge, and handshakes that will complete on
   // that edge are retired and scored here.
   always @(negedge clk) begin
      if (M_AXI_ARESET) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
         M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
         aw_got = 0; w_got = 0; ar_got = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         aw_pend = 0; w_pend = 0; ar_pend = 0;
         for (int i = 0; i < 16; i++) mem[i] = '0;
      end else begin
         if (aw_pend) check_eq("awvalid_hold", M_AXI_AWVALID, 1);
         if (w_pend)  check_eq("wvalid_hold", M_AXI_WVALID, 1);
         if (ar_pend) check_eq("arvalid_hold", M_AXI_ARVALID, 1);

         M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_cnt >= aw_dly);
         M_AXI_WREADY  = M_AXI_WVALID && !w_got && (w_cnt >= w_dly);
         M_AXI_BVALID  = aw_got && w_got && (b_cnt >= b_dly);
         M_AXI_BRESP   = bresp_mask[widx(aw_a)] ? 2'b10 : 2'b00;
         M_AXI_ARREADY = M_AXI_ARVALID && !ar_got;
         M_AXI_RVALID  = ar_got;
         M_AXI_RDATA   = mem[widx(ar_a)] ^ (corrupt_mask[widx(ar_a)] ? 32'h0000_0100 : 32'h0);
         M_AXI_RRESP   = 2'b00;

         if (M_AXI_BVALID && M_AXI_BREADY) begin
            wr_t e;
            mem[widx(aw_a)] = w_d;
            check_eq("wr_expected", wr_q.size() != 0, 1);
            if (wr_q.size() != 0) begin
               e = wr_q.pop_front();
               check_eq("wr_addr", aw_a, e.addr);
               check_eq("wr_data", w_d, e.data);
               $display("[TB] write addr=%08h data=%08h bresp=%0d", aw_a, w_d, M_AXI_BRESP);
            end
            aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end else if (aw_got && w_got) begin
            b_cnt++;
         end

         if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            aw_got = 1; aw_a = M_AXI_AWADDR;
         end else if (M_AXI_AWVALID) begin
            aw_cnt++;
         end
         if (M_AXI_WVALID && M_AXI_WREADY) begin
            w_got = 1; w_d = M_AXI_WDATA;
         end else if (M_AXI_WVALID) begin
            w_cnt++;
         end

         if (M_AXI_RVALID && M_AXI_RREADY) begin
            $display("[TB] read  addr=%08h data=%08h", ar_a, M_AXI_RDATA);
            ar_got = 0;
         end
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            ar_got = 1; ar_a = M_AXI_ARADDR;
            check_eq("rd_expected", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) check_eq("rd_addr", M_AXI_ARADDR, rd_q.pop_front());
         end

         aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
         w_pend  = M_AXI_WVALID && !M_AXI_WREADY;
         ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
      end
   end

   // One full run: queue the expected transactions, raise INIT, measure the
   // start latency and run length, then check the final status.
   task automatic run_txn(input logic [1:0] mode, input logic [3:0] cor, input logic [3:0] berr,
                          input int exp_cycles, input logic mid_pulse);
      int exp_errs;
      int cyc;
      corrupt_mask = cor;
      bresp_mask   = berr;
      exp_errs     = 0;
      for (int i = 0; i < 4; i++) begin
         if (mode != 2'b10) begin
            wr_q.push_back({BASE + 32'(4 * i), SEED + 32'(i)});
            if (berr[i]) exp_errs++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (mode != 2'b01) begin
            rd_q.push_back(BASE + 32'(4 * i));
            if (cor[i]) exp_errs++;
         end
      end
      if (exp_errs > 3) exp_errs = 3;

      @(negedge clk);
      MODE = mode;
      INIT_AXI_TXN = 1'b1;
      cyc = 0;
      while (!BUSY && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("start_latency", cyc, 3);
      check_eq("first_valid", (mode == 2'b10) ? {M_AXI_ARVALID, M_AXI_AWVALID} : {M_AXI_AWVALID & M_AXI_WVALID, M_AXI_ARVALID},
               2'b10);
      cyc = 1;
      while (!TXN_DONE && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (mid_pulse && cyc == 3) INIT_AXI_TXN = 1'b0;
         if (mid_pulse && cyc == 5) INIT_AXI_TXN = 1'b1;
      end
      if (exp_cycles > 0) check_eq("run_cycles", cyc, exp_cycles);
      check_eq("txn_done", TXN_DONE, 1);
      check_eq("error", ERROR, exp_errs != 0);
      check_eq("err_count", ERR_COUNT, exp_errs);
      check_eq("wr_q_left", wr_q.size(), 0);
      check_eq("rd_q_left", rd_q.size(), 0);
      $display("[TB] run mode=%0d cycles=%0d done=%0b error=%0b err_count=%0d", mode, cyc, TXN_DONE, ERROR, ERR_COUNT);
      INIT_AXI_TXN = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("done_hold", {BUSY, TXN_DONE, ERR_COUNT}, {1'b0, 1'b1, 2'(exp_errs)});
      wr_q.delete();
      rd_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      M_AXI_ARESET = 1'b1;
      repeat (2) @(negedge clk);
      M_AXI_ARESET = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check_eq("reset_ctrl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                              BUSY, TXN_DONE, ERROR, ERR_COUNT}, '0);
      check_eq("reset_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, '0);
      M_AXI_ARESET = 1'b0;
      repeat (2) @(negedge clk);

      // clean write/read-back
      run_txn(2'b00, 4'b0000, 4'b0000, 17, 1'b0);
      // corrupted reads on 1 and 3
      run_txn(2'b00, 4'b1010, 4'b0000, 17, 1'b0);
      // SLVERR on write 2 plus mismatch on read 2
      run_txn(2'b00, 4'b0100, 4'b0100, 17, 1'b0);
      // every beat fails: 2-bit counter saturates
      run_txn(2'b00, 4'b1111, 4'b1111, 17, 1'b0);

      // write-only then read-only on a cleared memory; a start edge during
      // the read run must be ignored
      do_reset();
      run_txn(2'b01, 4'b0000, 4'b0000, 9, 1'b0);
      run_txn(2'b10, 4'b0000, 4'b0000, 9, 1'b1);

      // independent AW/W with delayed WREADY and BVALID
      aw_dly = 0; w_dly = 3; b_dly = 2;
      run_txn(2'b00, 4'b0000, 4'b0000, 0, 1'b0);
      aw_dly = 0; w_dly = 0; b_dly = 0;

      // mode 11 behaves like mode 00
      run_txn(2'b11, 4'b0000, 4'b0000, 17, 1'b0);

      // reset in the middle of a write with WVALID pending
      w_dly = 3;
      @(negedge clk);
      MODE = 2'b00;
      INIT_AXI_TXN = 1'b1;
      cyc = 0;
      while (!(BUSY && M_AXI_WVALID) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("wvalid_before_reset", M_AXI_WVALID, 1);
      M_AXI_ARESET = 1'b1;
      @(negedge clk);
      check_eq("midrun_reset_ctrl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                                     BUSY, TXN_DONE, ERROR, ERR_COUNT}, '0);
      check_eq("midrun_reset_addr", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}, '0);
      @(negedge clk);
      M_AXI_ARESET = 1'b0;
      w_dly = 0;
      // INIT still high: no fresh edge, so no run
      repeat (6) @(negedge clk);
      check_eq("no_start_without_edge", BUSY, 0);
      INIT_AXI_TXN = 1'b0;
      repeat (2) @(negedge clk);
      run_txn(2'b00, 4'b0000, 4'b0000, 17, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
